// File: rtl/simd_result_unpacker.sv
// Serialises packed two-lane SIMD DSP products onto one lane-tagged valid/ready stream.
// The DSP cannot stall, so packed words are buffered and drops are flagged sticky.
module simd_result_unpacker #(
    parameter int LANE_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [1:0]          in_lane_en,
    input  logic [2*LANE_W-1:0] in_z,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANE_W-1:0]   out_z,
    output logic                out_lane,
    output logic                full,
    output logic                overflow,
    input  logic                clear_overflow,
    output logic [CNT_W-1:0]    lane0_count,
    output logic [CNT_W-1:0]    lane1_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [OW-1:0] FULL_CNT = OW'(DEPTH);

    typedef struct packed {
        logic [1:0]          en;
        logic [2*LANE_W-1:0] z;
    } entry_t;

    typedef enum logic {S_L0 = 1'b0, S_L1 = 1'b1} state_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] occ;
    state_t        state, state_nxt;
    logic          cur_lane, hs, push, pop, drop, empty;

    assign empty    = (occ == '0);
    assign full     = (occ == FULL_CNT);
    assign in_ready = !full;
    assign head     = mem[rd_ptr];

    // S_L0 skips straight to lane 1 when the head word carries no lane-0 product.
    assign cur_lane = (state == S_L1) ? 1'b1 : !head.en[0];
    assign hs       = !empty && out_ready;
    assign pop      = hs && (cur_lane || !head.en[1]);
    assign push     = in_valid && (in_lane_en != 2'b00) && (!full || pop);
    assign drop     = in_valid && (in_lane_en != 2'b00) && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_L0;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (hs) begin
            if (!cur_lane && head.en[1]) state_nxt = S_L1;
            else                         state_nxt = S_L0;
        end
    end

    always_comb begin
        out_valid = !empty;
        out_lane  = 1'b0;
        out_z     = '0;
        if (!empty) begin
            out_lane = cur_lane;
            out_z    = cur_lane ? head.z[2*LANE_W-1:LANE_W] : head.z[LANE_W-1:0];
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{en: in_lane_en, z: in_z};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow    <= 1'b0;
            lane0_count <= '0;
            lane1_count <= '0;
        end else begin
            if (drop)                overflow <= 1'b1;
            else if (clear_overflow) overflow <= 1'b0;
            if (hs && !cur_lane) lane0_count <= lane0_count + CNT_W'(1);
            if (hs && cur_lane)  lane1_count <= lane1_count + CNT_W'(1);
        end
    end
endmodule
